// File: rtl/pc_pkg.sv
// pc_pkg: shared constants for the program-counter unit.
//   PC_SEQ..PC_ERET : encodings of the 3-bit next-PC select (6,7 reserved)
//   BR_SHIFT        : left shift turning a word-unit branch offset into bytes
package pc_pkg;
  localparam logic [2:0] PC_SEQ    = 3'd0;
  localparam logic [2:0] PC_BRANCH = 3'd1;
  localparam logic [2:0] PC_JUMP   = 3'd2;
  localparam logic [2:0] PC_JR     = 3'd3;
  localparam logic [2:0] PC_TRAP   = 3'd4;
  localparam logic [2:0] PC_ERET   = 3'd5;

  localparam int BR_SHIFT = 2;
endpackage

// File: rtl/pc_sequencer_next_calc.sv
// pc_next_calc: combinational next-PC selection.
//   in : pc, epc, pc_src, beq, bne, zero, imm16, jump_index, jr_addr
//   out: next_pc, pc_plus4, taken (branch taken), trap (TRAP selected),
//        indirect (JR/ERET, target may be misaligned), rsvd (reserved select)
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int              WIDTH       = 32,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(32'h80)
) (
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_epc,
  input  logic [2:0]       i_pc_src,
  input  logic             i_beq,
  input  logic             i_bne,
  input  logic             i_zero,
  input  logic [15:0]      i_imm16,
  input  logic [25:0]      i_jump_index,
  input  logic [WIDTH-1:0] i_jr_addr,
  output logic [WIDTH-1:0] o_next_pc,
  output logic [WIDTH-1:0] o_pc_plus4,
  output logic             o_taken,
  output logic             o_trap,
  output logic             o_indirect,
  output logic             o_rsvd
);
  logic [WIDTH-1:0] w_br_off;
  logic             w_cond;

  assign o_pc_plus4 = i_pc + WIDTH'(4);
  // pc already points past the branch (fetch did PC+4), so offset adds to pc
  assign w_br_off   = {{(WIDTH-16){i_imm16[15]}}, i_imm16} << BR_SHIFT;
  assign w_cond     = (i_beq & i_zero) | (i_bne & ~i_zero);

  always_comb begin
    o_next_pc  = i_pc;
    o_taken    = 1'b0;
    o_trap     = 1'b0;
    o_indirect = 1'b0;
    o_rsvd     = 1'b0;
    case (i_pc_src)
      PC_SEQ:    o_next_pc = o_pc_plus4;
      PC_BRANCH: begin
        o_taken   = w_cond;
        o_next_pc = w_cond ? (i_pc + w_br_off) : o_pc_plus4;
      end
      PC_JUMP:   o_next_pc = {i_pc[WIDTH-1:28], i_jump_index, 2'b00};
      PC_JR:     begin o_next_pc = i_jr_addr; o_indirect = 1'b1; end
      PC_TRAP:   begin o_next_pc = TRAP_VECTOR; o_trap = 1'b1; end
      PC_ERET:   begin o_next_pc = i_epc; o_indirect = 1'b1; end
      default:   o_rsvd = 1'b1;
    endcase
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter register with link/EPC capture.
//   clk, reset (sync, active-high), pc_we, pc_src[2:0], beq, bne, zero,
//   imm16, jump_index, jr_addr, link -> pc, pc_plus4, link_addr, epc,
//   branch_taken (pulse), misalign (pulse).
// Optional: define MISALIGN_TRAP_EN to trap on misaligned JR/ERET targets;
// otherwise the low two target bits are cleared and misalign stays 0.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h80)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_we,
  input  logic [2:0]       pc_src,
  input  logic             beq,
  input  logic             bne,
  input  logic             zero,
  input  logic [15:0]      imm16,
  input  logic [25:0]      jump_index,
  input  logic [WIDTH-1:0] jr_addr,
  input  logic             link,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] link_addr,
  output logic [WIDTH-1:0] epc,
  output logic             branch_taken,
  output logic             misalign
);
  logic [WIDTH-1:0] r_pc, r_link, r_epc;
  logic             r_bt, r_mis;
  logic [WIDTH-1:0] w_next, w_pc_d;
  logic             w_taken, w_trap, w_indirect, w_rsvd, w_mis;

  pc_next_calc #(.WIDTH(WIDTH), .TRAP_VECTOR(TRAP_VECTOR)) u_calc (
    .i_pc(r_pc), .i_epc(r_epc), .i_pc_src(pc_src),
    .i_beq(beq), .i_bne(bne), .i_zero(zero), .i_imm16(imm16),
    .i_jump_index(jump_index), .i_jr_addr(jr_addr),
    .o_next_pc(w_next), .o_pc_plus4(pc_plus4), .o_taken(w_taken),
    .o_trap(w_trap), .o_indirect(w_indirect), .o_rsvd(w_rsvd)
  );

  always_comb begin
    w_mis  = 1'b0;
    w_pc_d = w_next;
`ifdef MISALIGN_TRAP_EN
    // Only register-sourced targets can carry nonzero low bits
    w_mis  = w_indirect & (|w_next[1:0]);
    if (w_mis) w_pc_d = TRAP_VECTOR;
`else
    w_pc_d = {w_next[WIDTH-1:2], 2'b00};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc   <= RESET_VECTOR;
      r_link <= '0;
      r_epc  <= '0;
      r_bt   <= 1'b0;
      r_mis  <= 1'b0;
    end else begin
      r_bt  <= 1'b0;
      r_mis <= 1'b0;
      // Reserved selects are a full no-op, including link capture
      if (pc_we && !w_rsvd) begin
        r_pc <= w_pc_d;
        if (link)           r_link <= r_pc;
        if (w_trap || w_mis) r_epc <= r_pc;
        r_bt  <= w_taken;
        r_mis <= w_mis;
      end
    end
  end

  assign pc           = r_pc;
  assign link_addr    = r_link;
  assign epc          = r_epc;
  assign branch_taken = r_bt;
  assign misalign     = r_mis;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_pkg::*;

  typedef struct {
    logic [31:0] pc, lnk, epc;
    logic        bt, mis;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, pc_we, beq, bne, zero, link;
  logic [2:0]  pc_src;
  logic [15:0] imm16;
  logic [25:0] jump_index;
  logic [31:0] jr_addr;
  logic [31:0] pc, pc_plus4, link_addr, epc;
  logic        branch_taken, misalign;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pc_we(pc_we), .pc_src(pc_src),
    .beq(beq), .bne(bne), .zero(zero), .imm16(imm16),
    .jump_index(jump_index), .jr_addr(jr_addr), .link(link),
    .pc(pc), .pc_plus4(pc_plus4), .link_addr(link_addr), .epc(epc),
    .branch_taken(branch_taken), .misalign(misalign)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: results appear after the update edge; sample on the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".pc"},   pc,        e.pc);
      chk({e.name, ".link"}, link_addr, e.lnk);
      chk({e.name, ".epc"},  epc,       e.epc);
      chk({e.name, ".bt"},   {31'b0, branch_taken}, {31'b0, e.bt});
      chk({e.name, ".mis"},  {31'b0, misalign},     {31'b0, e.mis});
      chk({e.name, ".pc4"},  pc_plus4,  e.pc + 32'd4);
    end
  end

  task automatic step(input string nm, input logic rst, input logic we,
                      input logic [2:0] src, input logic b_eq, input logic b_ne,
                      input logic z, input logic [15:0] imm, input logic [25:0] ji,
                      input logic [31:0] jr, input logic lk,
                      input logic [31:0] e_pc, input logic [31:0] e_lnk,
                      input logic [31:0] e_epc, input logic e_bt, input logic e_mis);
    exp_t e;
    reset = rst; pc_we = we; pc_src = src; beq = b_eq; bne = b_ne; zero = z;
    imm16 = imm; jump_index = ji; jr_addr = jr; link = lk;
    @(posedge clk); #1;
    e.pc = e_pc; e.lnk = e_lnk; e.epc = e_epc; e.bt = e_bt; e.mis = e_mis; e.name = nm;
    q.push_back(e);
    reset = 1'b0; pc_we = 1'b0; link = 1'b0; beq = 1'b0; bne = 1'b0;
  endtask

  task automatic setpc(input logic [31:0] v, input logic [31:0] l, input logic [31:0] ep);
    step("setpc", 0, 1, PC_JR, 0, 0, 0, 16'h0, 26'h0, v, 0, v, l, ep, 0, 0);
  endtask

  initial begin
    reset = 0; pc_we = 0; pc_src = 0; beq = 0; bne = 0; zero = 0;
    imm16 = 0; jump_index = 0; jr_addr = 0; link = 0;
    @(posedge clk); #1;
    step("reset", 1, 1, PC_SEQ, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    setpc(32'h8, 0, 0);
    step("seq", 0, 1, PC_SEQ, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 32'hC, 0, 0, 0, 0);
    setpc(32'hFFFF_FFFC, 0, 0);
    step("wrap", 0, 1, PC_SEQ, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
    setpc(32'h100, 0, 0);
    step("bne_tk", 0, 1, PC_BRANCH, 0, 1, 0, 16'hFFFE, 26'h0, 32'h0, 0, 32'hF8, 0, 0, 1, 0);
    setpc(32'h100, 0, 0);
    step("beq_nt", 0, 1, PC_BRANCH, 1, 0, 0, 16'h0010, 26'h0, 32'h0, 0, 32'h104, 0, 0, 0, 0);
    step("both_tk", 0, 1, PC_BRANCH, 1, 1, 1, 16'h0004, 26'h0, 32'h0, 0, 32'h114, 0, 0, 1, 0);
    step("hold", 0, 0, PC_SEQ, 0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 32'h114, 0, 0, 0, 0);
    setpc(32'h1000_0040, 0, 0);
    step("jump_lk", 0, 1, PC_JUMP, 0, 0, 0, 16'h0, 26'h5, 32'h0, 1,
         32'h1000_0014, 32'h1000_0040, 0, 0, 0);
    setpc(32'h200, 32'h1000_0040, 0);
    step("trap", 0, 1, PC_TRAP, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0,
         32'h80, 32'h1000_0040, 32'h200, 0, 0);
    step("eret", 0, 1, PC_ERET, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0,
         32'h200, 32'h1000_0040, 32'h200, 0, 0);
    step("rsvd", 0, 1, 3'd6, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0,
         32'h200, 32'h1000_0040, 32'h200, 0, 0);
    setpc(32'h40, 32'h1000_0040, 32'h200);
`ifdef MISALIGN_TRAP_EN
    step("jr_mis", 0, 1, PC_JR, 0, 0, 0, 16'h0, 26'h0, 32'h302, 0,
         32'h80, 32'h1000_0040, 32'h40, 0, 1);
`else
    step("jr_mis", 0, 1, PC_JR, 0, 0, 0, 16'h0, 26'h0, 32'h302, 0,
         32'h300, 32'h1000_0040, 32'h200, 0, 0);
`endif
    step("reset2", 1, 1, PC_SEQ, 0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 32'h0, 0, 0, 0, 0);
    // Let the monitor drain; an undrained queue counts as a failure
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
